// File: rtl/op_link_pkg.sv
// op_link_pkg: op word constants, FSM state type and keyboard word builder shared by the op send scheduler
package op_link_pkg;
  localparam int OP_WORD_W = 40;
  localparam logic [OP_WORD_W-1:0] OP_PWR_ON = 40'hC671000000;
  localparam logic [OP_WORD_W-1:0] OP_AUDIO_REQ = 40'h0700000000;
  localparam logic [7:0] OP_KBD_HDR = 8'hC6;
  localparam logic [7:0] OP_KBD_MOUSE = 8'h01;
  localparam logic [7:0] OP_KBD_KEY = 8'h10;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
  function automatic logic [OP_WORD_W-1:0] kbd_word(input logic is_mouse, input logic [15:0] data);
    return {OP_KBD_HDR, is_mouse ? OP_KBD_MOUSE : OP_KBD_KEY, 8'h00, data};
  endfunction
endpackage

// File: rtl/op_send_scheduler_if.sv
// op_send_scheduler_if: request/keyboard inputs and serial link outputs of the op send scheduler
//   master: drives power_on_req, audio_req, kbd_ready, kbd_is_mouse, kbd_data; sees kbd_ack, tx_data, tx_frame, busy
//   slave : the scheduler side of the same signals
interface op_send_scheduler_if;
  logic power_on_req;
  logic audio_req;
  logic kbd_ready;
  logic kbd_is_mouse;
  logic [15:0] kbd_data;
  logic kbd_ack;
  logic tx_data;
  logic tx_frame;
  logic busy;
  modport master(
    output power_on_req, audio_req, kbd_ready, kbd_is_mouse, kbd_data,
    input kbd_ack, tx_data, tx_frame, busy
  );
  modport slave(
    input power_on_req, audio_req, kbd_ready, kbd_is_mouse, kbd_data,
    output kbd_ack, tx_data, tx_frame, busy
  );
endinterface

// File: rtl/op_bit_serializer.sv
// op_bit_serializer: loads a 40-bit op word and shifts it out MSB-first, one bit every BIT_DIV clocks
//   clk, rst_n : clock, async active-low reset
//   load, word : capture word and start shifting
//   msb        : current serial bit (shift register MSB)
//   done       : high in the last clock of the last bit-time
module op_bit_serializer
  import op_link_pkg::*;
#(
  parameter int BIT_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [OP_WORD_W-1:0] word,
  output logic                 msb,
  output logic                 done
);
  localparam int DW = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
  logic [OP_WORD_W-1:0] shreg;
  logic [DW-1:0] div_cnt;
  logic [5:0] bit_cnt;
  logic active;
  logic tick;
  assign tick = active && div_cnt == DW'(BIT_DIV - 1);
  assign done = tick && bit_cnt == 6'(OP_WORD_W - 1);
  assign msb = shreg[OP_WORD_W-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      active <= 1'b0;
    end else if (load) begin
      shreg <= word;
      div_cnt <= '0;
      bit_cnt <= '0;
      active <= 1'b1;
    end else if (active) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        shreg <= shreg << 1;
        bit_cnt <= bit_cnt + 1'b1;
        active <= !done;
      end
    end
  end
endmodule

// File: rtl/op_send_scheduler.sv
// op_send_scheduler: latches op requests, arbitrates one per packet slot and serialises the 40-bit op word
//   clk, rst_n : clock, async active-low reset (released synchronously)
//   bus (slave): power_on_req, audio_req, kbd_ready, kbd_is_mouse, kbd_data in; kbd_ack, tx_data, tx_frame, busy out
//   OPSCHED_STARVE_GUARD_EN: when defined, keyboard beats audio once after STARVE_MAX consecutive audio wins
module op_send_scheduler
  import op_link_pkg::*;
#(
  parameter int BIT_DIV = 4,
  parameter int GAP_BITS = 2,
  parameter int STARVE_MAX = 3
) (
  input logic clk,
  input logic rst_n,
  op_send_scheduler_if.slave bus
);
  localparam int GAP_LEN = GAP_BITS * BIT_DIV;
  localparam int GW = $clog2(GAP_LEN + 1);
  logic [1:0] rst_q;
  logic rst_i_n;
  state_t state, nstate;
  logic pend_pwr, pend_aud;
  logic [GW-1:0] gap_cnt;
  logic g_pwr, g_aud, g_kbd, win, force_kbd, any_req, ser_msb, ser_done;
  logic [OP_WORD_W-1:0] word;
  // Reset asserts asynchronously everywhere but releases on a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 2'b00;
    else rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_i_n = rst_q[1];
`ifdef OPSCHED_STARVE_GUARD_EN
  localparam int SW = ($clog2(STARVE_MAX + 1) < 2) ? 2 : $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;
  assign force_kbd = bus.kbd_ready && starve_cnt >= SW'(STARVE_MAX);
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) starve_cnt <= '0;
    else if (state == LOAD)
      starve_cnt <= (!bus.kbd_ready || g_kbd) ? '0 :
                    (g_aud && starve_cnt < SW'(STARVE_MAX)) ? starve_cnt + 1'b1 : starve_cnt;
  end
`else
  assign force_kbd = 1'b0;
`endif
  always_comb begin
    g_pwr = state == LOAD && pend_pwr;
    g_aud = state == LOAD && !pend_pwr && pend_aud && !force_kbd;
    g_kbd = state == LOAD && !pend_pwr && bus.kbd_ready && (force_kbd || !pend_aud);
    win = g_pwr || g_aud || g_kbd;
    word = g_pwr ? OP_PWR_ON : g_aud ? OP_AUDIO_REQ : kbd_word(bus.kbd_is_mouse, bus.kbd_data);
    // Raw pulses count too so a request from IDLE reaches the line two clocks later
    any_req = pend_pwr || pend_aud || bus.kbd_ready || bus.power_on_req || bus.audio_req;
    nstate = state == IDLE ? (any_req ? LOAD : IDLE) :
             state == LOAD ? (win ? SHIFT : IDLE) :
             state == SHIFT ? (ser_done ? GAP : SHIFT) :
             (gap_cnt == GW'(GAP_LEN - 1) ? IDLE : GAP);
  end
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state <= IDLE;
      pend_pwr <= 1'b0;
      pend_aud <= 1'b0;
      gap_cnt <= '0;
    end else begin
      state <= nstate;
      pend_pwr <= bus.power_on_req || (pend_pwr && !g_pwr);
      pend_aud <= bus.audio_req || (pend_aud && !g_aud);
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
    end
  end
  op_bit_serializer #(.BIT_DIV(BIT_DIV)) u_ser (
    .clk(clk),
    .rst_n(rst_i_n),
    .load(win),
    .word(word),
    .msb(ser_msb),
    .done(ser_done)
  );
  assign bus.kbd_ack = g_kbd;
  assign bus.tx_frame = state == SHIFT;
  assign bus.tx_data = state == SHIFT && ser_msb;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_op_send_scheduler.sv
// tb_op_send_scheduler: directed scoreboard bench for op_send_scheduler
module tb_op_send_scheduler;
  localparam int BIT_DIV = 4;
  localparam int GAP_BITS = 2;
  localparam logic [39:0] W_PWR = 40'hC671000000;
  localparam logic [39:0] W_AUD = 40'h0700000000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int failed = 0;
  int frames = 0;
  int acks = 0;
  int ack_frame = 0;
  int idle_bad = 0;
  int k = 0;
  int f0, a0;
  logic [39:0] sh = '0;
  logic [39:0] q[$];
  op_send_scheduler_if bus();
  op_send_scheduler #(.BIT_DIV(BIT_DIV), .GAP_BITS(GAP_BITS), .STARVE_MAX(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Monitor: rebuild each frame from the first sample of every bit-time and score it
  always @(negedge clk) begin
    logic [39:0] e;
    if (!rst_n) begin
      k = 0;
      sh = '0;
    end else if (bus.tx_frame) begin
      if (k % BIT_DIV == 0) sh = {sh[38:0], bus.tx_data};
      k++;
    end else if (k != 0) begin
      chk("frame_len", 64'(k), 64'(40 * BIT_DIV));
      chk("frame_expected", 64'(q.size() != 0), 64'd1);
      e = (q.size() != 0) ? q.pop_front() : '0;
      chk("frame_word", 64'(sh), 64'(e));
      frames++;
      k = 0;
    end
    if (rst_n && bus.kbd_ack) begin
      acks++;
      ack_frame = frames;
    end
    if (!bus.tx_frame && bus.tx_data) idle_bad++;
  end
  task automatic pulse_pwr();
    @(negedge clk) bus.power_on_req = 1'b1;
    @(negedge clk) bus.power_on_req = 1'b0;
  endtask
  task automatic pulse_aud();
    @(negedge clk) bus.audio_req = 1'b1;
    @(negedge clk) bus.audio_req = 1'b0;
  endtask
  task automatic wait_frame(input logic want, input string tag);
    int n = 0;
    while (bus.tx_frame !== want && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < 3000), 64'd1);
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while ((q.size() != 0 || bus.busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < 5000), 64'd1);
  endtask
  task automatic kbd_packet(input logic mouse, input logic [15:0] data, input logic [39:0] exp, input string tag);
    int n = 0;
    f0 = frames;
    a0 = acks;
    @(negedge clk);
    bus.kbd_ready = 1'b1;
    bus.kbd_is_mouse = mouse;
    bus.kbd_data = data;
    q.push_back(exp);
    while (!bus.kbd_ack && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ack_seen"}, 64'(n < 2000), 64'd1);
    @(negedge clk) bus.kbd_ready = 1'b0;
    wait_idle({tag, "_idle"});
    chk({tag, "_acks"}, 64'(acks - a0), 64'd1);
    chk({tag, "_frames"}, 64'(frames - f0), 64'd1);
  endtask
  initial begin
    bus.power_on_req = 1'b0;
    bus.audio_req = 1'b0;
    bus.kbd_ready = 1'b0;
    bus.kbd_is_mouse = 1'b0;
    bus.kbd_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_data", 64'(bus.tx_data), 64'd0);
    chk("rst_tx_frame", 64'(bus.tx_frame), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_kbd_ack", 64'(bus.kbd_ack), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    // 1: power-on packet, two-clock latency to first bit
    f0 = frames;
    q.push_back(W_PWR);
    pulse_pwr();
    chk("t1_busy_load", 64'(bus.busy), 64'd1);
    chk("t1_frame_load", 64'(bus.tx_frame), 64'd0);
    @(negedge clk);
    chk("t1_frame_first", 64'(bus.tx_frame), 64'd1);
    chk("t1_first_bit", 64'(bus.tx_data), 64'd1);
    wait_idle("t1_idle");
    chk("t1_frames", 64'(frames - f0), 64'd1);
    chk("t1_busy_after", 64'(bus.busy), 64'd0);
    // 2: audio and keyboard together, audio first, ack in the second LOAD
    begin
      int n = 0;
      f0 = frames;
      a0 = acks;
      @(negedge clk);
      bus.audio_req = 1'b1;
      bus.kbd_ready = 1'b1;
      bus.kbd_is_mouse = 1'b0;
      bus.kbd_data = 16'h1234;
      q.push_back(W_AUD);
      q.push_back(40'hC610001234);
      @(negedge clk) bus.audio_req = 1'b0;
      while (!bus.kbd_ack && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("t2_ack_seen", 64'(n < 2000), 64'd1);
      @(negedge clk) bus.kbd_ready = 1'b0;
      wait_idle("t2_idle");
      chk("t2_acks", 64'(acks - a0), 64'd1);
      chk("t2_ack_after_frame", 64'(ack_frame - f0), 64'd1);
      chk("t2_frames", 64'(frames - f0), 64'd2);
    end
    // 3: mouse word, then a plain key word
    kbd_packet(1'b1, 16'hABCD, 40'hC60100ABCD, "t3_mouse");
    kbd_packet(1'b0, 16'h00FF, 40'hC6100000FF, "t3_key");
    // 4: repeated audio pulses during a shift coalesce into one packet
    f0 = frames;
    q.push_back(W_PWR);
    pulse_pwr();
    wait_frame(1'b1, "t4_frame");
    repeat (3) pulse_aud();
    q.push_back(W_AUD);
    wait_idle("t4_idle");
    chk("t4_frames", 64'(frames - f0), 64'd2);
    // 5: keyboard held while audio keeps asking
    f0 = frames;
    a0 = acks;
`ifdef OPSCHED_STARVE_GUARD_EN
    q.push_back(W_AUD);
    q.push_back(W_AUD);
    q.push_back(W_AUD);
    q.push_back(40'hC610005555);
    q.push_back(W_AUD);
`else
    q.push_back(W_AUD);
    q.push_back(W_AUD);
    q.push_back(W_AUD);
    q.push_back(W_AUD);
`endif
    @(negedge clk);
    bus.kbd_ready = 1'b1;
    bus.kbd_is_mouse = 1'b0;
    bus.kbd_data = 16'h5555;
    bus.audio_req = 1'b1;
    @(negedge clk) bus.audio_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wait_frame(1'b1, "t5_start");
      if (i < 4) pulse_aud();
      else bus.kbd_ready = 1'b0;
      wait_frame(1'b0, "t5_end");
    end
    wait_idle("t5_idle");
`ifdef OPSCHED_STARVE_GUARD_EN
    chk("t5_frames", 64'(frames - f0), 64'd5);
    chk("t5_acks", 64'(acks - a0), 64'd1);
`else
    chk("t5_frames", 64'(frames - f0), 64'd4);
    chk("t5_acks", 64'(acks - a0), 64'd0);
`endif
    // 6: reset in mid-shift aborts the frame and drops pending requests
    q.push_back(W_PWR);
    pulse_pwr();
    wait_frame(1'b1, "t6_frame");
    pulse_aud();
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_tx_frame", 64'(bus.tx_frame), 64'd0);
    chk("t6_tx_data", 64'(bus.tx_data), 64'd0);
    chk("t6_busy", 64'(bus.busy), 64'd0);
    q.delete();
    f0 = frames;
    a0 = acks;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("t6_busy_after", 64'(bus.busy), 64'd0);
    chk("t6_frames", 64'(frames - f0), 64'd0);
    chk("t6_acks", 64'(acks - a0), 64'd0);
    chk("tx_data_idle_low", 64'(idle_bad), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
